// File: rtl/ariane_pkg.sv
// Shared cache constants: index/tag widths, read-responder state and access-size encodings.
package ariane_pkg;

    localparam int unsigned DCACHE_INDEX_WIDTH = 12;
    localparam int unsigned DCACHE_TAG_WIDTH   = 44;

    typedef enum logic [1:0] {
        IDLE,
        MEM_REQ,
        MEM_WAIT,
        RESP
    } dcache_rd_state_e;

    localparam logic [1:0] SIZE_1B = 2'd0;
    localparam logic [1:0] SIZE_2B = 2'd1;
    localparam logic [1:0] SIZE_4B = 2'd2;
    localparam logic [1:0] SIZE_8B = 2'd3;

    // Clears the byte-offset bits below the natural alignment of the access size.
    function automatic logic [2:0] size_align_mask(input logic [1:0] size);
        return 3'b111 << size;
    endfunction

endpackage

// File: rtl/dcache_rsp_align.sv
// Combinational extract of a naturally aligned sub-word from a 64-bit line word,
// shifted down to bit 0 and zero-extended.
import ariane_pkg::*;

module dcache_rsp_align #(
    parameter int unsigned DATA_W = 64
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [2:0]        offset_i,
    input  logic [1:0]        size_i,
    output logic [DATA_W-1:0] data_o
);

    logic [2:0]        byte_off;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] keep;

    always_comb begin
        byte_off = offset_i & size_align_mask(size_i);
        shifted  = data_i >> {byte_off, 3'b000};
        keep     = '0;
        case (size_i)
            SIZE_1B: keep[7:0]  = '1;
            SIZE_2B: keep[15:0] = '1;
            SIZE_4B: keep[31:0] = '1;
            default: keep       = '1;
        endcase
        data_o = shifted & keep;
    end

endmodule

// File: rtl/dcache_rd_responder.sv
// Read-only data-cache responder: grants a request, fetches the 8-byte word from
// backing memory and returns the aligned slice. Optional error path: DCACHE_RD_RSP_ERR_EN.
import ariane_pkg::*;

module dcache_rd_responder #(
    parameter int unsigned INDEX_W = DCACHE_INDEX_WIDTH,
    parameter int unsigned TAG_W   = DCACHE_TAG_WIDTH,
    parameter int unsigned DATA_W  = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     data_req_i,
    input  logic                     data_we_i,
    input  logic [INDEX_W-1:0]       address_index_i,
    input  logic [TAG_W-1:0]         address_tag_i,
    input  logic [1:0]               data_size_i,
    input  logic                     kill_req_i,
    output logic                     data_gnt_o,
    output logic                     data_rvalid_o,
    output logic [DATA_W-1:0]        data_rdata_o,
    output logic                     illegal_we_o,
    output logic                     mem_req_o,
    output logic [INDEX_W+TAG_W-1:0] mem_addr_o,
    input  logic                     mem_gnt_i,
    input  logic                     mem_rvalid_i,
    input  logic [DATA_W-1:0]        mem_rdata_i,
    input  logic                     mem_err_i,
    output logic                     rsp_err_o
);

    localparam int unsigned ADDR_W = INDEX_W + TAG_W;

    dcache_rd_state_e    state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                killed_q, killed_d;
    logic                illegal_we_q, illegal_we_d;
    logic [DATA_W-1:0]   aligned;
    logic                abort;

`ifdef DCACHE_RD_RSP_ERR_EN
    logic err_q, err_d;
`else
    logic unused_mem_err;
    assign unused_mem_err = mem_err_i;
`endif

    assign abort = kill_req_i | flush_i;

    dcache_rsp_align #(
        .DATA_W (DATA_W)
    ) i_align (
        .data_i   (mem_rdata_i),
        .offset_i (addr_q[2:0]),
        .size_i   (size_q),
        .data_o   (aligned)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            size_q       <= '0;
            rdata_q      <= '0;
            killed_q     <= 1'b0;
            illegal_we_q <= 1'b0;
`ifdef DCACHE_RD_RSP_ERR_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            rdata_q      <= rdata_d;
            killed_q     <= killed_d;
            illegal_we_q <= illegal_we_d;
`ifdef DCACHE_RD_RSP_ERR_EN
            err_q        <= err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        rdata_d      = rdata_q;
        killed_d     = killed_q;
        illegal_we_d = 1'b0;
`ifdef DCACHE_RD_RSP_ERR_EN
        err_d        = err_q;
`endif
        case (state_q)
            IDLE: begin
                killed_d = 1'b0;
                if (data_req_i && !flush_i) begin
                    if (data_we_i) begin
                        illegal_we_d = 1'b1;
                    end else begin
                        addr_d  = {address_tag_i, address_index_i};
                        size_d  = data_size_i;
                        state_d = MEM_REQ;
                    end
                end
            end
            MEM_REQ: begin
                if (abort) killed_d = 1'b1;
                if (mem_gnt_i) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (mem_rvalid_i) begin
                    // A cancelled fetch drains the memory beat and leaves rdata untouched.
                    if (killed_q || abort) begin
                        state_d = IDLE;
                    end else begin
`ifdef DCACHE_RD_RSP_ERR_EN
                        rdata_d = mem_err_i ? '0 : aligned;
                        err_d   = mem_err_i;
`else
                        rdata_d = aligned;
`endif
                        state_d = RESP;
                    end
                end else if (abort) begin
                    killed_d = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_gnt_o    = 1'b0;
        mem_req_o     = 1'b0;
        data_rvalid_o = 1'b0;
        rsp_err_o     = 1'b0;
        case (state_q)
            IDLE:    data_gnt_o = data_req_i & ~flush_i;
            MEM_REQ: mem_req_o  = 1'b1;
            RESP: begin
                data_rvalid_o = 1'b1;
`ifdef DCACHE_RD_RSP_ERR_EN
                rsp_err_o     = err_q;
`endif
            end
            default: ;
        endcase
    end

    assign mem_addr_o   = {addr_q[ADDR_W-1:3], 3'b000};
    assign data_rdata_o = rdata_q;
    assign illegal_we_o = illegal_we_q;

endmodule

// File: tb/tb_dcache_rd_responder.sv
// Directed self-checking bench for dcache_rd_responder; expectations follow DCACHE_RD_RSP_ERR_EN.
import ariane_pkg::*;

module tb_dcache_rd_responder;

    localparam int unsigned IW = DCACHE_INDEX_WIDTH;
    localparam int unsigned TW = DCACHE_TAG_WIDTH;
    localparam int unsigned DW = 64;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          flush_i;
    logic          data_req_i;
    logic          data_we_i;
    logic [IW-1:0] address_index_i;
    logic [TW-1:0] address_tag_i;
    logic [1:0]    data_size_i;
    logic          kill_req_i;
    logic          data_gnt_o;
    logic          data_rvalid_o;
    logic [DW-1:0] data_rdata_o;
    logic          illegal_we_o;
    logic          mem_req_o;
    logic [IW+TW-1:0] mem_addr_o;
    logic          mem_gnt_i;
    logic          mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_err_i;
    logic          rsp_err_o;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    dcache_rd_responder #(
        .INDEX_W (IW),
        .TAG_W   (TW),
        .DATA_W  (DW)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .data_req_i      (data_req_i),
        .data_we_i       (data_we_i),
        .address_index_i (address_index_i),
        .address_tag_i   (address_tag_i),
        .data_size_i     (data_size_i),
        .kill_req_i      (kill_req_i),
        .data_gnt_o      (data_gnt_o),
        .data_rvalid_o   (data_rvalid_o),
        .data_rdata_o    (data_rdata_o),
        .illegal_we_o    (illegal_we_o),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .mem_err_i       (mem_err_i),
        .rsp_err_o       (rsp_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One read with single-cycle memory grant and data; kill_at selects the cycle
    // (1=MEM_REQ, 2=MEM_WAIT, 3=RESP) in which kill_req_i is pulsed, 0 for none.
    task automatic rd(input string nm, input logic [TW-1:0] tag, input logic [IW-1:0] idx,
                      input logic [1:0] sz, input logic [63:0] mdata, input logic merr,
                      input int kill_at, input logic exp_v, input logic [63:0] exp_d,
                      input logic exp_e, input logic [63:0] exp_a);
        address_tag_i   = tag;
        address_index_i = idx;
        data_size_i     = sz;
        data_we_i       = 1'b0;
        data_req_i      = 1'b1;
        #1 check({nm, ".gnt"}, 64'(data_gnt_o), 64'd1);
        tick();
        data_req_i      = 1'b0;
        address_tag_i   = '1;
        address_index_i = '1;
        kill_req_i      = (kill_at == 1);
        mem_gnt_i       = 1'b1;
        #1 check({nm, ".mem_req"}, 64'(mem_req_o), 64'd1);
        check({nm, ".mem_addr"}, 64'(mem_addr_o), exp_a);
        check({nm, ".early_rvalid"}, 64'(data_rvalid_o), 64'd0);
        tick();
        mem_gnt_i    = 1'b0;
        kill_req_i   = (kill_at == 2);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mdata;
        mem_err_i    = merr;
        #1 check({nm, ".mem_req_drop"}, 64'(mem_req_o), 64'd0);
        check({nm, ".wait_rvalid"}, 64'(data_rvalid_o), 64'd0);
        tick();
        mem_rvalid_i = 1'b0;
        mem_err_i    = 1'b0;
        mem_rdata_i  = '0;
        kill_req_i   = (kill_at == 3);
        #1 check({nm, ".rvalid"}, 64'(data_rvalid_o), 64'(exp_v));
        check({nm, ".rdata"}, data_rdata_o, exp_d);
        check({nm, ".rsp_err"}, 64'(rsp_err_o), 64'(exp_e));
        tick();
        kill_req_i = 1'b0;
        #1 check({nm, ".rvalid_off"}, 64'(data_rvalid_o), 64'd0);
        check({nm, ".rdata_hold"}, data_rdata_o, exp_d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0;
        address_index_i = '0; address_tag_i = '0; data_size_i = '0; kill_req_i = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
        #3;
        check("rst.gnt",    64'(data_gnt_o),    64'd0);
        check("rst.rvalid", 64'(data_rvalid_o), 64'd0);
        check("rst.rdata",  data_rdata_o,       64'd0);
        check("rst.ill_we", 64'(illegal_we_o),  64'd0);
        check("rst.mreq",   64'(mem_req_o),     64'd0);
        check("rst.maddr",  64'(mem_addr_o),    64'd0);
        check("rst.err",    64'(rsp_err_o),     64'd0);
        tick(); tick();
        rst_ni = 1'b1;
        tick();

        rd("full",   44'h1, 12'h008, SIZE_8B, 64'hDEAD_BEEF_0123_4567, 1'b0, 0, 1'b1, 64'hDEAD_BEEF_0123_4567, 1'b0, 64'h1008);
        rd("word_hi",44'h1, 12'h00C, SIZE_4B, 64'h1122_3344_5566_7788, 1'b0, 0, 1'b1, 64'h0000_0000_1122_3344, 1'b0, 64'h1008);
        rd("byte5",  44'h0, 12'h00D, SIZE_1B, 64'h1122_3344_5566_7788, 1'b0, 0, 1'b1, 64'h33, 1'b0, 64'h008);
        rd("half_mis",44'h0, 12'h003, SIZE_2B, 64'h1122_3344_5566_7788, 1'b0, 0, 1'b1, 64'h5566, 1'b0, 64'h000);
        rd("kill_wait",44'h2, 12'h010, SIZE_8B, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 2, 1'b0, 64'h5566, 1'b0, 64'h2010);
        rd("after_kill",44'h3, 12'h018, SIZE_8B, 64'h0F0E_0D0C_0B0A_0908, 1'b0, 0, 1'b1, 64'h0F0E_0D0C_0B0A_0908, 1'b0, 64'h3018);
        rd("kill_req", 44'h0, 12'h020, SIZE_8B, 64'h1234_5678_9ABC_DEF0, 1'b0, 1, 1'b0, 64'h0F0E_0D0C_0B0A_0908, 1'b0, 64'h020);
        rd("kill_resp",44'h0, 12'h028, SIZE_4B, 64'h1111_2222_3333_4444, 1'b0, 3, 1'b1, 64'h3333_4444, 1'b0, 64'h028);

        // Write request: granted, flagged, no memory traffic and no response.
        address_tag_i = 44'h9; address_index_i = 12'h040; data_size_i = SIZE_8B;
        data_we_i = 1'b1; data_req_i = 1'b1;
        #1 check("wr.gnt", 64'(data_gnt_o), 64'd1);
        tick();
        data_req_i = 1'b0; data_we_i = 1'b0;
        #1 check("wr.ill_we", 64'(illegal_we_o), 64'd1);
        check("wr.mreq1", 64'(mem_req_o), 64'd0);
        check("wr.rvalid1", 64'(data_rvalid_o), 64'd0);
        tick();
        check("wr.ill_we_pulse", 64'(illegal_we_o), 64'd0);
        check("wr.mreq2", 64'(mem_req_o), 64'd0);
        tick();
        check("wr.rvalid3", 64'(data_rvalid_o), 64'd0);

        // Flush together with a request in IDLE: no grant, nothing started.
        data_req_i = 1'b1; flush_i = 1'b1;
        #1 check("flush.gnt", 64'(data_gnt_o), 64'd0);
        tick();
        data_req_i = 1'b0; flush_i = 1'b0;
        #1 check("flush.mreq", 64'(mem_req_o), 64'd0);
        check("flush.ill_we", 64'(illegal_we_o), 64'd0);
        tick();

        // Memory grant withheld for 5 cycles while the requester keeps asking.
        address_tag_i = 44'h5; address_index_i = 12'h030; data_size_i = SIZE_8B; data_req_i = 1'b1;
        #1 check("stall.gnt", 64'(data_gnt_o), 64'd1);
        tick();
        address_index_i = 12'hFFF;
        for (int i = 0; i < 6; i++) begin
            mem_gnt_i = (i == 5);
            #1 check("stall.mreq", 64'(mem_req_o), 64'd1);
            check("stall.maddr", 64'(mem_addr_o), 64'h5030);
            check("stall.no_gnt", 64'(data_gnt_o), 64'd0);
            tick();
        end
        mem_gnt_i = 1'b0; data_req_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h0102_0304_0506_0708;
        #1 check("stall.wait_rvalid", 64'(data_rvalid_o), 64'd0);
        tick();
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        #1 check("stall.rvalid", 64'(data_rvalid_o), 64'd1);
        check("stall.rdata", data_rdata_o, 64'h0102_0304_0506_0708);
        tick();

        // Reset while waiting for memory data; the late beat must be ignored.
        address_tag_i = 44'h6; address_index_i = 12'h048; data_size_i = SIZE_8B; data_req_i = 1'b1;
        tick();
        data_req_i = 1'b0; mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0; rst_ni = 1'b0;
        #1 check("mrst.rdata", data_rdata_o, 64'd0);
        check("mrst.maddr", 64'(mem_addr_o), 64'd0);
        tick();
        rst_ni = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 64'hFFFF_0000_FFFF_0000;
        tick();
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        #1 check("mrst.rvalid", 64'(data_rvalid_o), 64'd0);
        check("mrst.rdata_kept", data_rdata_o, 64'd0);
        check("mrst.mreq", 64'(mem_req_o), 64'd0);
        tick();

`ifdef DCACHE_RD_RSP_ERR_EN
        rd("err", 44'h7, 12'h050, SIZE_8B, 64'hCAFE_F00D_CAFE_F00D, 1'b1, 0, 1'b1, 64'd0, 1'b1, 64'h7050);
`else
        rd("err", 44'h7, 12'h050, SIZE_8B, 64'hCAFE_F00D_CAFE_F00D, 1'b1, 0, 1'b1, 64'hCAFE_F00D_CAFE_F00D, 1'b0, 64'h7050);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache_rd_responder.md
DCACHE_RD_RESPONDER -- requirements
Module: dcache_rd_responder

Interface
REQ-001 Parameter INDEX_W, default DCACHE_INDEX_WIDTH, request index width.
REQ-002 Parameter TAG_W, default DCACHE_TAG_WIDTH, request tag width.
REQ-003 Parameter DATA_W, default 64, read data width.
REQ-004 clk_i  in  1  clock.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 flush_i  in  1  abandon in-flight response.
REQ-007 data_req_i  in  1  requester read/write request; held until granted.
REQ-008 data_we_i  in  1  write flag; writes unsupported.
REQ-009 address_index_i  in  INDEX_W  physical address low bits.
REQ-010 address_tag_i  in  TAG_W  physical address high bits.
REQ-011 data_size_i  in  2  log2 bytes: 0=1B, 1=2B, 2=4B, 3=8B.
REQ-012 kill_req_i  in  1  cancel the outstanding response.
REQ-013 data_gnt_o  out  1  request accepted.
REQ-014 data_rvalid_o  out  1  one-cycle response strobe.
REQ-015 data_rdata_o  out  DATA_W  response data.
REQ-016 illegal_we_o  out  1  one-cycle pulse on a dropped write.
REQ-017 mem_req_o / mem_addr_o  out  1 / INDEX_W+TAG_W  backing memory read; address is {tag, index}, 8-byte aligned (low 3 bits zero).
REQ-018 mem_gnt_i / mem_rvalid_i / mem_rdata_i / mem_err_i  in  1 / 1 / DATA_W / 1  memory grant, data strobe, data, error.
REQ-019 rsp_err_o  out  1  error qualifier, valid with data_rvalid_o.

Function
REQ-020 The FSM SHALL have states IDLE, MEM_REQ, MEM_WAIT, RESP.
REQ-021 In IDLE, data_gnt_o SHALL equal data_req_i combinationally; the other states SHALL drive 0.
REQ-022 A granted read SHALL latch address and size, then go to MEM_REQ.
REQ-023 A granted write SHALL pulse illegal_we_o the next cycle, access no memory, produce no rvalid, and stay in IDLE.
REQ-024 In MEM_REQ, mem_req_o SHALL be 1 with a stable address until mem_gnt_i, then go to MEM_WAIT.
REQ-025 MEM_WAIT on mem_rvalid_i SHALL register the data, then go to RESP.
REQ-026 RESP SHALL assert data_rvalid_o for exactly 1 cycle, then go to IDLE.
REQ-027 Minimum latency, grant to rvalid, SHALL be 3 cycles when mem_gnt_i and mem_rvalid_i are each asserted the cycle after request.
REQ-028 For size < 3, data_rdata_o SHALL be the naturally aligned slice at address bits [2:0], shifted to bit 0 and zero-extended.
REQ-029 For size 3, data_rdata_o SHALL be the full word.
REQ-030 Misaligned sub-word addresses SHALL use the aligned slice (low bits truncated).
REQ-031 If kill_req_i or flush_i is asserted in MEM_REQ or MEM_WAIT, the memory transaction SHALL complete and the response SHALL be suppressed.
REQ-032 If kill_req_i or flush_i is asserted in RESP, the strobe SHALL still be driven.
REQ-033 If flush_i and data_req_i are asserted together in IDLE, the flush SHALL win: no grant.
REQ-034 data_rdata_o SHALL hold its last value outside RESP.

Reset
REQ-035 On reset, the state SHALL be IDLE and all outputs SHALL be 0, including data_rdata_o, rsp_err_o and the latched address.
REQ-036 Reset mid-transaction SHALL abandon it; a later mem_rvalid_i received in IDLE SHALL be ignored.

Configuration
REQ-037 Macro DCACHE_RD_RSP_ERR_EN defined: mem_err_i SHALL be captured with the data; rsp_err_o=1 in RESP and data_rdata_o forced to 0 on error.
REQ-038 Macro undefined: mem_err_i SHALL be ignored and rsp_err_o tied to 0.

Structure
REQ-039 The state enum and size encoding constants SHALL live in ariane_pkg; INDEX/TAG widths come from ariane_pkg constants.
REQ-040 The slice/zero-extend logic SHALL be sub-module dcache_rsp_align (combinational); the FSM and registers stay in the top.

Verification
REQ-041 Read with tag 0x1, index 0x008, size 3, mem data 0xDEAD_BEEF_0123_4567 at 1-cycle latencies -> gnt at t0, mem_addr 0x1008, rvalid at t3 with the full word.
REQ-042 Size 2 at index 0x00C (bit2=1), mem data 0x1122_3344_5566_7788 -> rdata 0x0000_0000_1122_3344.
REQ-043 Write request -> gnt=1, illegal_we_o at t1, mem_req_o stays 0, no rvalid.
REQ-044 Read followed by kill_req_i during MEM_WAIT -> memory handshake completes, no rvalid; the next read succeeds normally.
REQ-045 mem_gnt_i withheld 5 cycles -> mem_req_o and mem_addr_o stable for 6 cycles, data_gnt_o=0 throughout.
REQ-046 DCACHE_RD_RSP_ERR_EN defined with mem_err_i=1 -> rvalid with rdata 0 and rsp_err_o=1; macro undefined -> mem data passed, rsp_err_o=0.
